// File: rtl/panel_pkg.sv
// Shared front-panel definitions: scheduler state encoding, owner-width helper,
// and default timing constants used by panel timers.
// Pure declarations; no logic or latency of its own.
package panel_pkg;

   // Repeat scheduler phases: idle, waiting for the first repeat, steady repeating.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FIRST  = 2'd1,
      ST_REPEAT = 2'd2
   } rs_state_e;

   // Default hold-to-repeat timing, in core clock cycles.
   localparam int PANEL_FIRST_DELAY  = 50;
   localparam int PANEL_START_PERIOD = 20;
   localparam int PANEL_MIN_PERIOD   = 4;
   localparam int PANEL_STEP         = 4;
   localparam int PANEL_ACCEL_PULSES = 4;

   // Width of an index into n requesters, never narrower than one bit.
   function automatic int ow_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/repeat_gap_timer.sv
// Loadable down counter that flags the last cycle of a programmed gap.
// Latency: load at edge k with value V -> expire_o high during cycle k+V-1.
// No backpressure; a load always wins over counting, and the count parks at zero.
module repeat_gap_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: reload on request, otherwise count down and stop at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Expire on the final counted cycle so the owner can act on the following edge.
   assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/repeat_scheduler.sv
// Hold-to-repeat scheduler: grants one held button the shared repeat engine.
// Latency: press pulse one cycle after req is sampled; release drops busy next cycle.
// No backpressure; pulses are fire-and-forget strobes, non-owner requests wait.
module repeat_scheduler
   import panel_pkg::*;
#(
   parameter int N_REQ        = 2,
   parameter int FIRST_DELAY  = PANEL_FIRST_DELAY,
   parameter int START_PERIOD = PANEL_START_PERIOD,
   parameter int MIN_PERIOD   = PANEL_MIN_PERIOD,
   parameter int STEP         = PANEL_STEP,
   parameter int ACCEL_PULSES = PANEL_ACCEL_PULSES
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_REQ-1:0]             req,
   output logic [N_REQ-1:0]             pulse,
   output logic [ow_width(N_REQ)-1:0]   owner,
   output logic                         busy
);

   localparam int OW = ow_width(N_REQ);
   localparam int PW = $clog2(((FIRST_DELAY > START_PERIOD) ? FIRST_DELAY : START_PERIOD) + 1);
   localparam int SW = $clog2(ACCEL_PULSES + 1);

   rs_state_e        state_q, state_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic             busy_q, busy_d;
   logic [N_REQ-1:0] pulse_q, pulse_d;
   logic [PW-1:0]    period_q, period_d;
   logic [SW-1:0]    step_q, step_d;

   logic             any_req;
   logic [OW-1:0]    grant_idx;
   logic             owner_held;
   logic [PW-1:0]    period_dec;
   logic             tmr_load;
   logic [PW-1:0]    tmr_val;
   logic             tmr_expire;

   // Fixed-priority arbiter: lowest held index wins.
   always_comb begin
      any_req   = 1'b0;
      grant_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            any_req   = 1'b1;
            grant_idx = OW'(i);
         end
      end
   end

   assign owner_held = req[owner_q];

   // One acceleration step down, clamped at the floor so it can never wrap.
   assign period_dec = (int'(period_q) >= MIN_PERIOD + STEP) ? (period_q - PW'(STEP))
                                                             : PW'(MIN_PERIOD);

   // Next-state decode; release is tested before expiry so it wins a tie.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      busy_d   = busy_q;
      pulse_d  = '0;
      period_d = period_q;
      step_d   = step_q;
      tmr_load = 1'b0;
      tmr_val  = PW'(FIRST_DELAY);
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d  = ST_FIRST;
               owner_d  = grant_idx;
               busy_d   = 1'b1;
               pulse_d  = N_REQ'(1) << grant_idx;
               period_d = PW'(START_PERIOD);
               step_d   = '0;
               tmr_load = 1'b1;
               tmr_val  = PW'(FIRST_DELAY);
            end
         end
         ST_FIRST: begin
            if (!owner_held) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (tmr_expire) begin
               state_d          = ST_REPEAT;
               pulse_d[owner_q] = 1'b1;
               tmr_load         = 1'b1;
               tmr_val          = period_q;
            end
         end
         ST_REPEAT: begin
            if (!owner_held) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (tmr_expire) begin
               pulse_d[owner_q] = 1'b1;
               tmr_load         = 1'b1;
               if (step_q == SW'(ACCEL_PULSES - 1)) begin
                  period_d = period_dec;
                  step_d   = '0;
                  tmr_val  = period_dec;
               end else begin
                  step_d  = step_q + SW'(1);
                  tmr_val = period_q;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Scheduler state and registered outputs; reset aborts without a trailing pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         busy_q   <= 1'b0;
         pulse_q  <= '0;
         period_q <= PW'(START_PERIOD);
         step_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         busy_q   <= busy_d;
         pulse_q  <= pulse_d;
         period_q <= period_d;
         step_q   <= step_d;
      end
   end

   repeat_gap_timer #(
      .W (PW)
   ) u_gap_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expire_o   (tmr_expire)
   );

   assign pulse = pulse_q;
   assign owner = owner_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_repeat_scheduler.sv
// Bench for repeat_scheduler: fixed vectors, hand-built corner sequences and
// randomized holds checked against a schedule-arithmetic reference model.
module tb_repeat_scheduler;

   localparam int FD = 10;
   localparam int SP = 8;
   localparam int MP = 3;
   localparam int ST = 2;
   localparam int AP = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req, req_flat;
   logic [1:0] pulse, pulse_flat;
   logic       owner, owner_flat;
   logic       busy, busy_flat;

   always #5 clk = ~clk;

   repeat_scheduler #(
      .N_REQ(2), .FIRST_DELAY(FD), .START_PERIOD(SP), .MIN_PERIOD(MP), .STEP(ST), .ACCEL_PULSES(AP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .pulse(pulse), .owner(owner), .busy(busy)
   );

   repeat_scheduler #(
      .N_REQ(2), .FIRST_DELAY(FD), .START_PERIOD(SP), .MIN_PERIOD(MP), .STEP(0), .ACCEL_PULSES(AP)
   ) dut_flat (
      .clk(clk), .rst_n(rst_n), .req(req_flat), .pulse(pulse_flat), .owner(owner_flat), .busy(busy_flat)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Fixed vectors: per-cycle input and the outputs expected in that cycle.
   typedef struct {
      logic [1:0] req;
      logic [1:0] pulse;
      logic       busy;
      logic       owner;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic [1:0] r, input logic [1:0] p, input logic b, input logic o, input int n);
      vec_t v;
      v.req = r; v.pulse = p; v.busy = b; v.owner = o;
      for (int k = 0; k < n; k++) tv.push_back(v);
   endtask

   // Gap before pulse n+1 of a held button: first delay, then a period that
   // falls by STEP every AP gaps and bottoms out at the floor.
   function automatic int gap(input int n);
      int p;
      if (n == 0) return FD;
      p = SP - ST * ((n - 1) / AP);
      return (p < MP) ? MP : p;
   endfunction

   logic       m_busy;
   int         m_owner;
   logic [1:0] m_pulse;
   int         m_next;
   int         m_n;

   // Outputs of cycle c+1 from outputs of cycle c and the request seen in cycle c.
   task automatic model_step(input logic [1:0] r, input int c);
      m_pulse = 2'b00;
      if (!m_busy) begin
         if (r != 2'b00) begin
            m_owner          = r[0] ? 0 : 1;
            m_busy           = 1'b1;
            m_pulse[m_owner] = 1'b1;
            m_next           = c + 1 + gap(0);
            m_n              = 1;
         end
      end else if (!r[m_owner]) begin
         m_busy = 1'b0;
      end else if (c + 1 == m_next) begin
         m_pulse[m_owner] = 1'b1;
         m_next           = m_next + gap(m_n);
         m_n++;
      end
   endtask

   int sched [10];

   function automatic logic sched_pulse(input int rel);
      for (int k = 0; k < 10; k++) if (sched[k] == rel) return 1'b1;
      return (rel > 53) && ((rel - 53) % 3 == 0);
   endfunction

   initial begin
      logic [1:0] r;
      int         len;
      int         c;
      logic       exp_p;

      sched = '{1, 11, 19, 27, 33, 39, 43, 47, 50, 53};

      // Short press and release.
      add(2'b01, 2'b00, 1'b0, 1'b0, 1);
      add(2'b01, 2'b01, 1'b1, 1'b0, 1);
      add(2'b01, 2'b00, 1'b1, 1'b0, 3);
      add(2'b00, 2'b00, 1'b1, 1'b0, 1);
      add(2'b00, 2'b00, 1'b0, 1'b0, 4);
      // Release on the very cycle the first gap expires.
      add(2'b01, 2'b00, 1'b0, 1'b0, 1);
      add(2'b01, 2'b01, 1'b1, 1'b0, 1);
      add(2'b01, 2'b00, 1'b1, 1'b0, 8);
      add(2'b00, 2'b00, 1'b1, 1'b0, 1);
      add(2'b00, 2'b00, 1'b0, 1'b0, 3);
      // Both pressed together, owner 0 released, handover to requester 1.
      add(2'b11, 2'b00, 1'b0, 1'b0, 1);
      add(2'b11, 2'b01, 1'b1, 1'b0, 1);
      add(2'b11, 2'b00, 1'b1, 1'b0, 9);
      add(2'b11, 2'b01, 1'b1, 1'b0, 1);
      add(2'b11, 2'b00, 1'b1, 1'b0, 3);
      add(2'b10, 2'b00, 1'b1, 1'b0, 1);
      add(2'b10, 2'b00, 1'b0, 1'b0, 1);
      add(2'b10, 2'b10, 1'b1, 1'b1, 1);
      add(2'b10, 2'b00, 1'b1, 1'b1, 9);
      add(2'b10, 2'b10, 1'b1, 1'b1, 1);
      add(2'b00, 2'b00, 1'b1, 1'b1, 1);
      add(2'b00, 2'b00, 1'b0, 1'b1, 3);

      rst_n    = 1'b0;
      req      = 2'b00;
      req_flat = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      check("reset_pulse", 32'(pulse), 32'd0);
      check("reset_owner", 32'(owner), 32'd0);
      check("reset_busy",  32'(busy),  32'd0);
      check("reset_flat_busy", 32'(busy_flat), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < tv.size(); i++) begin
         req = tv[i].req;
         @(negedge clk);
         check($sformatf("vec%0d_pulse", i), 32'(pulse), 32'(tv[i].pulse));
         check($sformatf("vec%0d_busy", i),  32'(busy),  32'(tv[i].busy));
         check($sformatf("vec%0d_owner", i), 32'(owner), 32'(tv[i].owner));
         @(posedge clk);
         #1;
      end

      // Long hold of requester 0 with requester 1 glitching, alongside a
      // no-acceleration engine held the same way.
      for (int rel = 0; rel < 75; rel++) begin
         req      = {(rel > 0) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1};
         req_flat = 2'b01;
         @(negedge clk);
         exp_p = sched_pulse(rel);
         check($sformatf("hold%0d_pulse", rel), 32'(pulse), {30'd0, 1'b0, exp_p});
         check($sformatf("hold%0d_busy", rel), 32'(busy), (rel > 0) ? 32'd1 : 32'd0);
         if (rel > 0) check($sformatf("hold%0d_owner", rel), 32'(owner), 32'd0);
         exp_p = (rel == 1) || (rel >= 11 && (rel - 11) % 8 == 0);
         check($sformatf("flat%0d_pulse", rel), 32'(pulse_flat), {31'd0, exp_p});
         @(posedge clk);
         #1;
      end
      req      = 2'b00;
      req_flat = 2'b00;
      repeat (3) begin
         @(posedge clk);
         #1;
      end

      // Reset asserted mid-repeat while a pulse is out.
      for (int rel = 0; rel < 27; rel++) begin
         req = 2'b10;
         @(posedge clk);
         #1;
      end
      check("prereset_pulse", 32'(pulse), 32'd2);
      check("prereset_owner", 32'(owner), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_pulse", 32'(pulse), 32'd0);
      check("async_reset_busy",  32'(busy),  32'd0);
      check("async_reset_owner", 32'(owner), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomized holds against the reference model; the first segment is a
      // re-hold that must restart from the first delay.
      m_busy  = 1'b0;
      m_owner = 0;
      m_pulse = 2'b00;
      m_next  = 0;
      m_n     = 0;
      c       = 0;
      for (int seg = 0; seg < 60; seg++) begin
         r   = (seg == 0) ? 2'b01 : 2'($urandom_range(0, 3));
         len = (seg == 0) ? 25 : $urandom_range(1, 70);
         for (int k = 0; k < len; k++) begin
            req = r;
            @(negedge clk);
            check($sformatf("rnd%0d_pulse", c), 32'(pulse), 32'(m_pulse));
            check($sformatf("rnd%0d_busy", c),  32'(busy),  32'(m_busy));
            check($sformatf("rnd%0d_owner", c), 32'(owner), 32'(m_owner));
            model_step(r, c);
            c++;
            @(posedge clk);
            #1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
